// File: rtl/if_stage_pkg.sv
// Shared MIPS pipeline definitions: fetch FSM states, nop encoding,
// opcode field bounds and the default reset PC.
package mips_pkg;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DROP  = 2'd3
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam int          OPCODE_MSB       = 31;
  localparam int          OPCODE_LSB       = 26;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Sequential fetch address; wraps modulo 2^32.
  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/if_stage_if.sv
// Instruction-memory req/ack handshake between the fetch stage and imem.
interface imem_if;
  logic        req;
  logic [31:0] addr;
  logic        ack;
  logic [31:0] rdata;

  modport master (output req, output addr, input ack, input rdata);
  modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/if_stage_ifid_reg.sv
// IF/ID pipeline register: flush-to-nop, load, bubble, otherwise hold.
module ifid_reg
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        load,
  input  logic        bubble,
  input  logic [31:0] load_instr,
  input  logic [31:0] load_pc4,
  output logic        valid,
  output logic [31:0] instr,
  output logic [31:0] pc4,
  output logic [5:0]  opcode
);

  // Flush beats load; a stalled cycle asserts none of the controls and holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      instr <= NOP_INSTR;
      pc4   <= 32'h0000_0000;
    end else if (flush) begin
      valid <= 1'b0;
      instr <= NOP_INSTR;
      pc4   <= 32'h0000_0000;
    end else if (load) begin
      valid <= 1'b1;
      instr <= load_instr;
      pc4   <= load_pc4;
    end else if (bubble) begin
      valid <= 1'b0;
      instr <= NOP_INSTR;
      pc4   <= 32'h0000_0000;
    end else begin
      valid <= valid;
      instr <= instr;
      pc4   <= pc4;
    end
  end

  assign opcode = instr[OPCODE_MSB:OPCODE_LSB];

endmodule

// File: rtl/if_stage.sv
// MIPS instruction-fetch stage: PC, one-outstanding imem fetch FSM with a
// one-entry skid buffer, redirect handling, and the IF/ID register.
module if_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  imem_if.master      imem,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        ifid_valid,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc4,
  output logic [5:0]  opcode
);

  fetch_state_t state_r;
  logic [31:0]  pc_r;
  logic [31:0]  redir_buf_r;
  logic [31:0]  skid_r;
  logic         req_r;

  logic         load_s;
  logic         bubble_s;
  logic [31:0]  load_instr_s;
  logic [31:0]  pc4_s;

  assign imem.req  = req_r;
  assign imem.addr = pc_r;
  assign pc4_s     = pc_plus4(pc_r);

  // IF/ID controls; the pc4 of a loaded instruction is always pc+4 since the
  // PC only advances once the instruction has entered IF/ID.
  always_comb begin
    load_s       = 1'b0;
    bubble_s     = 1'b0;
    load_instr_s = imem.rdata;
    case (state_r)
      ST_FETCH: begin
        if (redirect) begin
          load_s = 1'b0;
        end else if (imem.ack) begin
          load_s = !stall || !ifid_valid;
        end else begin
          bubble_s = !stall;
        end
      end
      ST_HOLD: begin
        load_instr_s = skid_r;
        if (!redirect && !stall) begin
          load_s = 1'b1;
        end else begin
          load_s = 1'b0;
        end
      end
      default: begin
        load_s = 1'b0;
      end
    endcase
  end

  // Fetch FSM; req_r is high exactly in FETCH and DROP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_BOOT;
      pc_r        <= RESET_PC;
      redir_buf_r <= 32'h0000_0000;
      skid_r      <= 32'h0000_0000;
      req_r       <= 1'b0;
    end else begin
      case (state_r)
        ST_BOOT: begin
          state_r <= ST_FETCH;
          req_r   <= 1'b1;
        end
        ST_FETCH: begin
          if (redirect) begin
            if (imem.ack) begin
              pc_r <= redirect_pc;
            end else begin
              redir_buf_r <= redirect_pc;
              state_r     <= ST_DROP;
            end
          end else if (imem.ack) begin
            if (!stall || !ifid_valid) begin
              pc_r <= pc4_s;
            end else begin
              skid_r  <= imem.rdata;
              state_r <= ST_HOLD;
              req_r   <= 1'b0;
            end
          end
        end
        ST_HOLD: begin
          if (redirect) begin
            skid_r  <= 32'h0000_0000;
            pc_r    <= redirect_pc;
            state_r <= ST_FETCH;
            req_r   <= 1'b1;
          end else if (!stall) begin
            skid_r  <= 32'h0000_0000;
            pc_r    <= pc4_s;
            state_r <= ST_FETCH;
            req_r   <= 1'b1;
          end
        end
        ST_DROP: begin
          // The squashed request must finish at its original address first.
          if (imem.ack) begin
            pc_r    <= redirect ? redirect_pc : redir_buf_r;
            state_r <= ST_FETCH;
          end else if (redirect) begin
            redir_buf_r <= redirect_pc;
          end
        end
        default: begin
          state_r <= ST_BOOT;
          req_r   <= 1'b0;
        end
      endcase
    end
  end

  ifid_reg u_ifid_reg (
    .clk        (clk),
    .rst        (rst),
    .flush      (redirect),
    .load       (load_s),
    .bubble     (bubble_s),
    .load_instr (load_instr_s),
    .load_pc4   (pc4_s),
    .valid      (ifid_valid),
    .instr      (ifid_instr),
    .pc4        (ifid_pc4),
    .opcode     (opcode)
  );

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: randomized stall/redirect/latency traffic
// plus directed reset, stall, drop, flush, wrap and async-reset scenarios.
module tb_if_stage;

  typedef struct packed {
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc4;
  } ifid_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        ifid_valid;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc4;
  logic [5:0]  opcode;

  logic        stall2 = 1'b0;
  logic        redirect2 = 1'b0;
  logic [31:0] redirect_pc2 = 32'h0;
  logic        ifid_valid2;
  logic [31:0] ifid_instr2;
  logic [31:0] ifid_pc42;
  logic [5:0]  opcode2;

  imem_if imem ();
  imem_if imem2 ();

  if_stage dut (
    .clk(clk), .rst(rst), .imem(imem), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .ifid_valid(ifid_valid), .ifid_instr(ifid_instr),
    .ifid_pc4(ifid_pc4), .opcode(opcode)
  );

  if_stage #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
    .clk(clk), .rst(rst), .imem(imem2), .stall(stall2), .redirect(redirect2),
    .redirect_pc(redirect_pc2), .ifid_valid(ifid_valid2), .ifid_instr(ifid_instr2),
    .ifid_pc4(ifid_pc42), .opcode(opcode2)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
    end
  endtask

  // Instruction memory model: latency in cycles of waiting before ack.
  int mem_lat = 0;
  int cur_lat = 0;
  int wait_cnt = 0;
  bit rand_lat = 1'b0;
  bit hash_data = 1'b0;
  bit late_ack = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a, input bit hash);
    return hash ? (a * 32'h0019_660D + 32'h3C6E_F35F) : 32'h8C08_0004;
  endfunction

  initial begin : memory
    imem.ack = 1'b0;
    imem.rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (late_ack) begin
        imem.ack = 1'b1;
        imem.rdata = 32'hDEAD_BEEF;
      end else if (rst || !imem.req) begin
        imem.ack = 1'b0;
        imem.rdata = $urandom;
        if (rst) wait_cnt = 0;
      end else if (wait_cnt >= (rand_lat ? cur_lat : mem_lat)) begin
        imem.ack = 1'b1;
        imem.rdata = mem_word(imem.addr, hash_data);
        wait_cnt = 0;
        cur_lat = int'($urandom_range(0, 3));
      end else begin
        imem.ack = 1'b0;
        imem.rdata = $urandom;
        wait_cnt++;
      end
    end
  end

  initial begin : memory2
    imem2.ack = 1'b0;
    imem2.rdata = 32'h1234_5678;
    forever begin
      @(negedge clk);
      imem2.ack = imem2.req;
    end
  end

  // Scoreboard: delivered fetches queue up; IF/ID must take them in order.
  ifid_t       exp_q[$];
  ifid_t       m;
  ifid_t       e;
  logic [31:0] exp_pc;
  logic [31:0] inflight_addr;
  logic [31:0] addr_p;
  logic        req_p;
  bit          squash;
  bit          inflight;

  initial begin : monitor
    m = '0; exp_pc = 32'h0; req_p = 1'b0; addr_p = 32'h0;
    squash = 1'b0; inflight = 1'b0; inflight_addr = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        exp_q.delete();
        exp_pc = 32'h0;
        squash = 1'b0;
        inflight = 1'b0;
        m = '0;
      end else begin
        if (req_p) begin
          if (inflight) chk("addr_stable", addr_p, inflight_addr);
          inflight = !imem.ack;
          inflight_addr = addr_p;
        end
        if (req_p && imem.ack) begin
          if (redirect || squash) begin
            squash = 1'b0;
          end else begin
            chk("fetch_addr", addr_p, exp_pc);
            e.valid = 1'b1;
            e.instr = imem.rdata;
            e.pc4 = exp_pc + 32'd4;
            exp_q.push_back(e);
            exp_pc = exp_pc + 32'd4;
          end
        end else if (req_p && redirect) begin
          squash = 1'b1;
        end
        if (redirect) begin
          exp_q.delete();
          exp_pc = redirect_pc;
          m = '0;
        end else if (!(stall && m.valid)) begin
          if (exp_q.size() > 0) m = exp_q.pop_front();
          else m = '0;
        end
        chk("ifid_valid", 32'(ifid_valid), 32'(m.valid));
        chk("ifid_instr", ifid_instr, m.instr);
        chk("ifid_pc4", ifid_pc4, m.pc4);
        chk("opcode", 32'(opcode), 32'(m.instr[31:26]));
        chk("skid_depth", (exp_q.size() <= 1) ? 32'd1 : 32'd0, 32'd1);
      end
      req_p = imem.req;
      addr_p = imem.addr;
    end
  end

  logic [31:0] old_addr;

  initial begin : stimulus
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("boot_req", 32'(imem.req), 32'd0);
    chk("boot_req2", 32'(imem2.req), 32'd0);
    @(posedge clk); #1;
    chk("first_req", 32'(imem.req), 32'd1);
    chk("first_addr", imem.addr, 32'h0);
    chk("wrap_first_addr", imem2.addr, 32'hFFFF_FFFC);
    @(posedge clk); #1;
    chk("second_addr", imem.addr, 32'h4);
    chk("first_opcode", 32'(opcode), 32'h23);
    chk("first_pc4", ifid_pc4, 32'h4);
    chk("wrap_pc4", ifid_pc42, 32'h0);
    chk("wrap_next_addr", imem2.addr, 32'h0);
    @(posedge clk); #1;
    chk("third_addr", imem.addr, 32'h8);
    @(negedge clk); stall = 1'b1;
    @(posedge clk); #1;
    chk("hold_req", 32'(imem.req), 32'd0);
    chk("hold_pc4", ifid_pc4, 32'h8);
    @(posedge clk); #1;
    chk("hold_req2", 32'(imem.req), 32'd0);
    chk("hold_pc4_2", ifid_pc4, 32'h8);
    @(negedge clk); stall = 1'b0;
    @(posedge clk); #1;
    chk("unstall_pc4", ifid_pc4, 32'hC);
    chk("unstall_addr", imem.addr, 32'hC);
    mem_lat = 2;
    old_addr = imem.addr;
    @(negedge clk); redirect = 1'b1; redirect_pc = 32'h40;
    @(posedge clk); #1;
    chk("drop_addr", imem.addr, old_addr);
    chk("drop_valid", 32'(ifid_valid), 32'd0);
    @(negedge clk); redirect = 1'b0;
    @(posedge clk); #1;
    chk("drop_addr2", imem.addr, old_addr);
    @(posedge clk); #1;
    chk("drop_refetch", imem.addr, 32'h40);
    chk("drop_refetch_req", 32'(imem.req), 32'd1);
    chk("drop_valid2", 32'(ifid_valid), 32'd0);
    mem_lat = 0;
    @(posedge clk); #1;
    chk("after_drop_pc4", ifid_pc4, 32'h44);
    @(negedge clk); stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h80;
    @(posedge clk); #1;
    chk("flush_valid", 32'(ifid_valid), 32'd0);
    chk("flush_instr", ifid_instr, 32'h0);
    chk("flush_opcode", 32'(opcode), 32'd0);
    chk("flush_addr", imem.addr, 32'h80);
    @(negedge clk); stall = 1'b0; redirect = 1'b0;
    @(posedge clk); #1;
    chk("flush_next_pc4", ifid_pc4, 32'h84);
    hash_data = 1'b1;
    rand_lat = 1'b1;

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      stall = ($urandom_range(0, 99) < 30);
      redirect = ($urandom_range(0, 99) < 8);
      redirect_pc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC
                                               : (32'($urandom_range(0, 255)) << 2);
    end
    @(negedge clk); stall = 1'b0; redirect = 1'b0;
    @(posedge clk); #1;
    rand_lat = 1'b0;
    mem_lat = 0;
    repeat (4) @(posedge clk);
    #1;
    mem_lat = 3;
    old_addr = imem.addr;
    @(negedge clk); redirect = 1'b1; redirect_pc = 32'h100;
    @(posedge clk); #1;
    chk("rst_drop_addr", imem.addr, old_addr);
    chk("rst_drop_req", 32'(imem.req), 32'd1);
    @(negedge clk); redirect = 1'b0;
    #2; rst = 1'b1;
    #1;
    chk("async_req", 32'(imem.req), 32'd0);
    chk("async_addr", imem.addr, 32'h0);
    chk("async_valid", 32'(ifid_valid), 32'd0);
    chk("async_instr", ifid_instr, 32'h0);
    chk("async_pc4", ifid_pc4, 32'h0);
    chk("async_opcode", 32'(opcode), 32'd0);
    @(posedge clk); #1;
    late_ack = 1'b1;
    mem_lat = 0;
    @(negedge clk); rst = 1'b0;
    #1;
    chk("late_ack_boot_req", 32'(imem.req), 32'd0);
    @(posedge clk); #1;
    late_ack = 1'b0;
    chk("late_ack_pc", imem.addr, 32'h0);
    chk("late_ack_req", 32'(imem.req), 32'd1);
    repeat (5) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
